// File: rtl/bit_serializer_if.sv
// Word-in / bit-out handshake bundle for the bit serializer.
// master: word producer and bit consumer side; slave: the serializer itself.
interface bit_serializer_if #(
    parameter int unsigned WIDTH = 8
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic             out_bit;
    logic             out_valid;
    logic             out_ready;
    logic             out_first;
    logic             out_last;
    logic             busy;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        input  out_bit,
        input  out_valid,
        output out_ready,
        input  out_first,
        input  out_last,
        input  busy
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        output out_bit,
        output out_valid,
        input  out_ready,
        output out_first,
        output out_last,
        output busy
    );
endinterface

// File: rtl/bit_serializer.sv
// Parallel-to-serial transmitter: one WIDTH-bit word per handshake, emitted one bit per
// accepted cycle with first/last framing. A new word can load on the last-bit transfer,
// so back-to-back words stream without an idle cycle.
module bit_serializer #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1
) (
    input logic             clk,
    input logic             rst,
    bit_serializer_if.slave bus
);
    localparam int unsigned     CW       = $clog2(WIDTH);
    localparam logic [CW-1:0]   LAST_IDX = CW'(WIDTH - 1);

    typedef enum logic {StIdle, StShift} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic shifting;
    logic is_last;
    logic xfer;
    logic in_ready;
    logic load;

    // Handshake decode and next-state: a load wins over the final-bit return to idle.
    always_comb begin
        shifting = (state_q == StShift);
        is_last  = shifting && (cnt_q == LAST_IDX);
        xfer     = shifting && bus.out_ready;
        // Combinational from out_ready on purpose: enables the zero-bubble reload.
        in_ready = !rst && (!shifting || (xfer && is_last));
        load     = bus.in_valid && in_ready;

        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;

        if (load) begin
            state_d = StShift;
            shreg_d = bus.in_data;
            cnt_d   = '0;
        end else if (xfer) begin
            if (is_last) begin
                state_d = StIdle;
                shreg_d = '0;
                cnt_d   = '0;
            end else begin
                // Shift toward the output end, zero fill behind.
                if (MSB_FIRST) begin
                    shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
                end else begin
                    shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
                end
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // State, shift register and bit index; reset aborts any word in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            shreg_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
        end
    end

    // Outputs come from registered state only (apart from in_ready).
    always_comb begin
        bus.in_ready  = in_ready;
        bus.out_valid = shifting;
        bus.busy      = shifting;
        bus.out_first = shifting && (cnt_q == '0);
        bus.out_last  = is_last;
        bus.out_bit   = 1'b0;
        if (shifting) begin
            bus.out_bit = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];
        end
    end
endmodule

// File: tb/tb_bit_serializer.sv
// Self-checking bench: two serializers (MSB-first and LSB-first) share one stimulus stream.
// A word-level model tracks how many bits of the current word remain and predicts every
// output each cycle; received bit streams are also reassembled and compared to the words.
module tb_bit_serializer;
    localparam int unsigned W = 8;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    bit_serializer_if #(.WIDTH(W)) bus_m ();
    bit_serializer_if #(.WIDTH(W)) bus_l ();

    assign bus_l.in_data   = bus_m.in_data;
    assign bus_l.in_valid  = bus_m.in_valid;
    assign bus_l.out_ready = bus_m.out_ready;

    bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) u_dut_msb (
        .clk (clk),
        .rst (rst),
        .bus (bus_m.slave)
    );

    bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) u_dut_lsb (
        .clk (clk),
        .rst (rst),
        .bus (bus_l.slave)
    );

    int n_total = 0;
    int n_bad   = 0;

    // Reference model: bits of the current word still to be transferred (0 = idle).
    int         remaining = 0;
    logic [W-1:0] cur = '0;
    logic [W-1:0] rx_m = '0;
    logic [W-1:0] rx_l = '0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, " in_ready"},  bus_m.in_ready,  0);
        check_eq({tag, " out_valid"}, bus_m.out_valid, 0);
        check_eq({tag, " out_bit"},   bus_m.out_bit,   0);
        check_eq({tag, " out_first"}, bus_m.out_first, 0);
        check_eq({tag, " out_last"},  bus_m.out_last,  0);
        check_eq({tag, " busy"},      bus_m.busy,      0);
        check_eq({tag, " lsb valid"}, bus_l.out_valid, 0);
        check_eq({tag, " lsb bit"},   bus_l.out_bit,   0);
    endtask

    // One clock: drive inputs after negedge, check against model, advance model at posedge.
    task automatic cycle(input logic v, input logic [W-1:0] d, input logic r);
        logic exp_rdy;
        logic exp_bm;
        logic exp_bl;
        int   k;
        @(negedge clk);
        bus_m.in_valid  = v;
        bus_m.in_data   = d;
        bus_m.out_ready = r;
        #1;
        exp_rdy = (remaining == 0) || (remaining == 1 && r);
        exp_bm  = 1'b0;
        exp_bl  = 1'b0;
        if (remaining > 0) begin
            k      = W - remaining;
            exp_bm = cur[W-1-k];
            exp_bl = cur[k];
        end
        check_eq("in_ready",  bus_m.in_ready,  exp_rdy);
        check_eq("out_valid", bus_m.out_valid, remaining > 0);
        check_eq("busy",      bus_m.busy,      remaining > 0);
        check_eq("out_first", bus_m.out_first, remaining == W);
        check_eq("out_last",  bus_m.out_last,  remaining == 1);
        check_eq("out_bit",   bus_m.out_bit,   exp_bm);
        check_eq("lsb in_ready",  bus_l.in_ready,  exp_rdy);
        check_eq("lsb out_valid", bus_l.out_valid, remaining > 0);
        check_eq("lsb out_first", bus_l.out_first, remaining == W);
        check_eq("lsb out_last",  bus_l.out_last,  remaining == 1);
        check_eq("lsb out_bit",   bus_l.out_bit,   exp_bl);
        if (remaining > 0 && r) begin
            rx_m = {rx_m[W-2:0], bus_m.out_bit};
            rx_l = {bus_l.out_bit, rx_l[W-1:1]};
        end
        @(posedge clk);
        if (v && exp_rdy) begin
            cur       = d;
            remaining = W;
        end else if (remaining > 0 && r) begin
            remaining--;
        end
    endtask

    // Send one word with out_ready high throughout, then check the reassembled bits.
    task automatic send_word(input logic [W-1:0] d, input string tag);
        cycle(1'b1, d, 1'b1);
        for (int i = 0; i < W; i++) cycle(1'b0, '0, 1'b1);
        check_eq({tag, " rx msb"}, rx_m, d);
        check_eq({tag, " rx lsb"}, rx_l, d);
    endtask

    // Assert reset between clock edges; outputs must clear without waiting for an edge.
    task automatic async_reset(input string tag);
        #2;
        rst = 1'b1;
        bus_m.in_valid = 1'b0;
        #1;
        check_all_zero(tag);
        remaining = 0;
        @(negedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst             = 1'b1;
        bus_m.in_valid  = 1'b0;
        bus_m.in_data   = '0;
        bus_m.out_ready = 1'b0;
        @(negedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;

        // Single words; 0x01 distinguishes bit order on the LSB-first instance.
        send_word(8'hA5, "a5");
        cycle(1'b0, '0, 1'b1);
        send_word(8'h01, "01");
        cycle(1'b0, '0, 1'b1);

        // Back-to-back: in_valid held, second word loads on the first word's last bit.
        cycle(1'b1, 8'hF0, 1'b1);
        for (int i = 0; i < W; i++) cycle(1'b1, 8'h0F, 1'b1);
        check_eq("b2b first rx", rx_m, 8'hF0);
        for (int i = 0; i < W; i++) cycle(1'b0, '0, 1'b1);
        check_eq("b2b second rx", rx_m, 8'h0F);
        check_eq("b2b second rx lsb", rx_l, 8'h0F);

        // Backpressure with pattern 1,0,0,1,...; bounded loop.
        cycle(1'b1, 8'h3C, 1'b1);
        for (int i = 0; i < 40 && remaining > 0; i++) begin
            cycle(1'b0, '0, (i % 3) == 0);
        end
        check_eq("bp drained", remaining, 0);
        check_eq("bp rx", rx_m, 8'h3C);
        check_eq("bp rx lsb", rx_l, 8'h3C);

        // Async reset after the 3rd bit of 0xFF, then a full 0x81.
        cycle(1'b1, 8'hFF, 1'b1);
        for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1);
        async_reset("midword rst");
        send_word(8'h81, "after rst");
        cycle(1'b0, '0, 1'b1);

        // in_valid while busy and stalled: new data must not be captured.
        cycle(1'b1, 8'h5A, 1'b1);
        cycle(1'b0, '0, 1'b1);
        for (int i = 0; i < 3; i++) cycle(1'b1, 8'hC3, 1'b0);
        for (int i = 0; i < W - 1; i++) cycle(1'b0, '0, 1'b1);
        check_eq("stall hold rx", rx_m, 8'h5A);
        cycle(1'b0, '0, 1'b1);

        // Randomized traffic against the model, with occasional mid-stream resets.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 499) == 0) async_reset("rand rst");
            else cycle($urandom_range(0, 3) != 0, W'($urandom), $urandom_range(0, 3) != 0);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
